// File: rtl/adc_interleave_seq.sv
// adc_interleave_seq: round-robin channel sequencer for a registered 32:1 ADC mux with frame counting
//   clk           rising-edge clock
//   GlobalReset   asynchronous active-high reset
//   start         begin sequencing from IDLE (last_ch_cfg latched)
//   stop          finish the current frame, drain, return to IDLE
//   last_ch_cfg   last channel index of a frame
//   x_adc_select  channel select to the mux
//   x_adc         mux output, valid one cycle after its select
//   sample_out    captured sample, sample_ch its channel, sample_valid strobe
//   frame_done    strobe with the last channel's sample, frame_cnt completed frames
//   busy          high outside IDLE
module adc_interleave_seq #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              GlobalReset,
   input  logic              start,
   input  logic              stop,
   input  logic [SEL_W-1:0]  last_ch_cfg,
   output logic [SEL_W-1:0]  x_adc_select,
   input  logic [DATA_W-1:0] x_adc,
   output logic [DATA_W-1:0] sample_out,
   output logic [SEL_W-1:0]  sample_ch,
   output logic              sample_valid,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;
   logic [SEL_W-1:0] sel, sel_d, last_ch;
   logic stop_pend, iss_d, drain_cnt, issue, at_last, last_sample;
   always_ff @(posedge clk or posedge GlobalReset)
      if (GlobalReset) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      at_last = sel == last_ch;
      state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? ((stop_pend && at_last) ? DRAIN : RUN) :
                  (drain_cnt ? IDLE : DRAIN);
   end
   always_comb begin
      busy = state != IDLE;
      issue = state == RUN;
      x_adc_select = sel;
   end
   // sel_d/iss_d align the issued select with the registered mux output
   assign last_sample = iss_d && sel_d == last_ch;
   always_ff @(posedge clk or posedge GlobalReset)
      if (GlobalReset) begin
         sel <= '0;
         sel_d <= '0;
         last_ch <= '0;
         stop_pend <= 1'b0;
         iss_d <= 1'b0;
         drain_cnt <= 1'b0;
         sample_out <= '0;
         sample_ch <= '0;
         sample_valid <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt <= '0;
      end else begin
         sel <= (issue && !at_last) ? sel + 1'b1 : '0;
         drain_cnt <= state == DRAIN ? ~drain_cnt : 1'b0;
         stop_pend <= state == IDLE ? (start & stop) : (stop_pend | (issue & stop));
         iss_d <= issue;
         sel_d <= sel;
         sample_valid <= iss_d;
         frame_done <= last_sample;
         if (iss_d) begin
            sample_out <= x_adc;
            sample_ch <= sel_d;
         end
         if (last_sample) frame_cnt <= frame_cnt + 1'b1;
         if (state == IDLE && start) begin
            last_ch <= last_ch_cfg;
            frame_cnt <= '0;
         end
      end
endmodule

// File: tb/tb_adc_interleave_seq.sv
// tb_adc_interleave_seq: randomized directed bench with a frame-level reference model
module tb_adc_interleave_seq;
   logic clk = 1'b0;
   logic rst, start, stop;
   logic [4:0] cfg;
   logic [4:0] sel, sel4, ch, ch4;
   logic [31:0] x_adc, x_adc4, s_out, s_out4;
   logic vld, vld4, done, done4, busy, busy4;
   logic [15:0] cnt;
   logic [3:0] cnt4;
   logic [31:0] mem [32];
   logic [31:0] hold_data;
   int hold_ch;
   int n_total = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      x_adc <= mem[sel];
      x_adc4 <= mem[sel4];
   end
   adc_interleave_seq u_dut (.clk(clk), .GlobalReset(rst), .start(start), .stop(stop),
      .last_ch_cfg(cfg), .x_adc_select(sel), .x_adc(x_adc), .sample_out(s_out),
      .sample_ch(ch), .sample_valid(vld), .frame_done(done), .frame_cnt(cnt), .busy(busy));
   adc_interleave_seq #(.CNT_W(4)) u_dut4 (.clk(clk), .GlobalReset(rst), .start(start),
      .stop(stop), .last_ch_cfg(cfg), .x_adc_select(sel4), .x_adc(x_adc4),
      .sample_out(s_out4), .sample_ch(ch4), .sample_valid(vld4), .frame_done(done4),
      .frame_cnt(cnt4), .busy(busy4));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic chk_all_zero(input string tag);
      chk({tag, "_sel"}, 32'(sel), 0);
      chk({tag, "_out"}, s_out, 0);
      chk({tag, "_ch"}, 32'(ch), 0);
      chk({tag, "_vld"}, 32'(vld), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_cnt"}, 32'(cnt), 0);
      chk({tag, "_cnt4"}, 32'(cnt4), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      hold_ch = 0;
      hold_data = 0;
   endtask
   // stop_c < 0: stop given together with start; otherwise stop pulses in run cycle stop_c.
   // The frame in progress once stop is seen completes; stop takes effect one cycle late.
   task automatic run(input int c_cfg, input int stop_c);
      int l = c_cfg + 1;
      int total = stop_c < 0 ? l : ((stop_c + 1) / l) * l + l;
      int i, exp_cnt;
      start = 1'b1;
      stop = stop_c < 0;
      cfg = 5'(c_cfg);
      @(posedge clk); #1;
      for (int c = 0; c <= total + 3; c++) begin
         start = c <= total + 1 ? 1'($urandom) : 1'b0;
         stop = (c == stop_c) || (c > stop_c && 1'($urandom)) || (c >= total + 2 && 1'($urandom));
         cfg = 5'($urandom);
         @(negedge clk);
         chk("sel", 32'(sel), c < total ? 32'(c % l) : 0);
         chk("sel4", 32'(sel4), c < total ? 32'(c % l) : 0);
         chk("busy", 32'(busy), 32'(c < total + 2));
         chk("vld", 32'(vld), 32'(c >= 2 && c < total + 2));
         chk("vld4", 32'(vld4), 32'(c >= 2 && c < total + 2));
         if (c >= 2 && c < total + 2) begin
            i = c - 2;
            hold_ch = i % l;
            hold_data = mem[hold_ch];
         end
         chk("ch", 32'(ch), 32'(hold_ch));
         chk("data", s_out, hold_data);
         chk("data4", s_out4, hold_data);
         chk("done", 32'(done), 32'(c >= 2 && c < total + 2 && hold_ch == l - 1));
         exp_cnt = c < 2 ? 0 : ((c - 2 < total - 1 ? c - 2 : total - 1) + 1) / l;
         chk("cnt", 32'(cnt), exp_cnt % 65536);
         chk("cnt4", 32'(cnt4), exp_cnt % 16);
         @(posedge clk); #1;
      end
      start = 1'b0;
      stop = 1'b0;
   endtask
   initial begin
      rst = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      cfg = '0;
      for (int k = 0; k < 32; k++) mem[k] = 32'(k) * 32'h1000;
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run(31, 5);
      for (int k = 0; k < 32; k++) mem[k] = $urandom;
      run(3, 9);
      run(7, -1);
      run(0, 20);
      run(1, 32);
      start = 1'b1;
      cfg = 5'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_all_zero("async_rst");
      @(negedge clk); #2;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_vld", 32'(vld), 0);
         chk("post_rst_busy", 32'(busy), 0);
      end
      @(posedge clk); #1;
      for (int r = 0; r < 6; r++) begin
         int rc = $urandom_range(0, 31);
         run(rc, $urandom_range(0, 3 * (rc + 1)));
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
